// File: rtl/guitar_fx_pkg.sv
// Shared definitions for the guitar effects chain: sample width, unity gain
// and the noise gate state encoding.
package guitar_fx_pkg;

    localparam int unsigned SAMPLE_W_DEF = 24;
    localparam int unsigned GAIN_W       = 9;
    localparam logic [GAIN_W-1:0] UNITY_GAIN = 9'd256;

    typedef enum logic [2:0] {
        StClosed,
        StAttack,
        StOpen,
        StHold,
        StRelease
    } gate_state_e;

endpackage

// File: rtl/envelope_follower.sv
// Peak envelope detector: rectifies the signed input with saturation, jumps to
// new peaks and decays exponentially otherwise.
module envelope_follower
    import guitar_fx_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
    parameter int unsigned DECAY_SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                valid_i,
    output logic [SAMPLE_W-1:0] env_next_o
);

    localparam logic [SAMPLE_W-1:0] MaxPos = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] MinNeg = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [SAMPLE_W-1:0] abs_val;
    logic [SAMPLE_W-1:0] env_d;
    logic [SAMPLE_W-1:0] env_q;

    always_comb begin
        // The most negative code has no positive twin, so pin it to full scale.
        if (sample_i == MinNeg) begin
            abs_val = MaxPos;
        end else if (sample_i[SAMPLE_W-1]) begin
            abs_val = -sample_i;
        end else begin
            abs_val = sample_i;
        end

        if (abs_val > env_q) begin
            env_d = abs_val;
        end else begin
            env_d = env_q - (env_q >> DECAY_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q <= '0;
        end else if (valid_i) begin
            env_q <= env_d;
        end
    end

    assign env_next_o = env_d;

endmodule

// File: rtl/noise_gate.sv
// Envelope-driven noise gate with attack/hold/release gain ramp and bypass.
// Output is registered one clock after each qualified input sample.
module noise_gate
    import guitar_fx_pkg::*;
#(
    parameter int unsigned          SAMPLE_W     = SAMPLE_W_DEF,
    parameter logic [SAMPLE_W-1:0]  OPEN_TH      = 24'h010000,
    parameter logic [SAMPLE_W-1:0]  CLOSE_TH     = 24'h008000,
    parameter int unsigned          HOLD_SAMPLES = 2400,
    parameter int unsigned          ATK_STEP     = 16,
    parameter int unsigned          REL_STEP     = 1,
    parameter int unsigned          DECAY_SHIFT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                enable,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                out_valid,
    output logic                gate_open
);

    localparam int unsigned      HoldW    = $clog2(HOLD_SAMPLES + 2);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_SAMPLES);
    localparam logic [9:0]       Unity10  = {1'b0, UNITY_GAIN};
    localparam logic [9:0]       AtkStep  = 10'(ATK_STEP);
    localparam logic [9:0]       RelStep  = 10'(REL_STEP);

    gate_state_e         state_q;
    logic [GAIN_W-1:0]   gain_q;
    logic [HoldW-1:0]    hold_cnt_q;
    logic                gate_open_q;
    logic [SAMPLE_W-1:0] sample_out_q;
    logic                out_valid_q;

    logic [SAMPLE_W-1:0] env_next;
    logic                opening;
    logic                closing;
    logic [9:0]          gain_up;
    logic [GAIN_W-1:0]   gain_dn;
    logic                at_unity;

    envelope_follower #(
        .SAMPLE_W    (SAMPLE_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_env (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_i   (sample_in),
        .valid_i    (sample_valid),
        .env_next_o (env_next)
    );

    always_comb begin
        opening = (env_next >= OPEN_TH);
        closing = (env_next < CLOSE_TH);

        gain_up = {1'b0, gain_q} + AtkStep;
        if (gain_up > Unity10) begin
            gain_up = Unity10;
        end
        at_unity = (gain_up == Unity10);

        if ({1'b0, gain_q} > RelStep) begin
            gain_dn = gain_q - RelStep[GAIN_W-1:0];
        end else begin
            gain_dn = '0;
        end
    end

    // Entering ATTACK applies the first attack step on the same sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StClosed;
            gain_q      <= '0;
            hold_cnt_q  <= '0;
            gate_open_q <= 1'b0;
        end else if (sample_valid) begin
            unique case (state_q)
                StClosed: begin
                    if (opening) begin
                        gain_q      <= gain_up[GAIN_W-1:0];
                        state_q     <= at_unity ? StOpen : StAttack;
                        gate_open_q <= 1'b1;
                    end
                end
                StAttack: begin
                    gain_q <= gain_up[GAIN_W-1:0];
                    if (at_unity) begin
                        state_q <= StOpen;
                    end
                end
                StOpen: begin
                    if (closing) begin
                        state_q    <= StHold;
                        hold_cnt_q <= HoldInit;
                    end
                end
                StHold: begin
                    if (opening) begin
                        state_q <= StOpen;
                    end else if (hold_cnt_q == '0) begin
                        state_q     <= StRelease;
                        gate_open_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HoldW'(1);
                    end
                end
                StRelease: begin
                    if (opening) begin
                        gain_q      <= gain_up[GAIN_W-1:0];
                        state_q     <= at_unity ? StOpen : StAttack;
                        gate_open_q <= 1'b1;
                    end else begin
                        gain_q <= gain_dn;
                        if (gain_dn == '0) begin
                            state_q <= StClosed;
                        end
                    end
                end
                default: begin
                    state_q     <= StClosed;
                    gain_q      <= '0;
                    gate_open_q <= 1'b0;
                end
            endcase
        end
    end

    logic signed [SAMPLE_W+9:0] product;
    logic                       unused_product;

    assign product        = $signed(sample_in) * $signed({1'b0, gain_q});
    assign unused_product = ^{product[SAMPLE_W+9:SAMPLE_W+8], product[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            out_valid_q <= sample_valid;
            if (sample_valid) begin
                sample_out_q <= enable ? product[SAMPLE_W+7:8] : sample_in;
            end
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign gate_open  = gate_open_q;

endmodule

// File: tb/tb_noise_gate.sv
// Directed self-checking bench for noise_gate.
module tb_noise_gate;

    logic        clk;
    logic        rst_n;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        enable;
    logic [23:0] sample_out;
    logic        out_valid;
    logic        gate_open;

    int n_vec;
    int n_err;

    logic [23:0] got_out;
    logic        got_valid;
    logic        got_gate;

    noise_gate dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .enable       (enable),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .gate_open    (gate_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for one clock, then capture outputs 1 time unit later.
    task automatic send(input logic [23:0] d, input logic en);
        sample_in    = d;
        enable       = en;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        got_out   = sample_out;
        got_valid = out_valid;
        got_gate  = gate_open;
    endtask

    task automatic idle();
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        got_out   = sample_out;
        got_valid = out_valid;
        got_gate  = gate_open;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sample_valid = 1'b0;
        enable       = 1'b1;
        sample_in    = 24'h0;
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sample_out !== 24'h0) begin
            n_err++;
            $display("FAIL reset_out: got %h want %h", sample_out, 24'h0);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_vec++;
        if (gate_open !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gate: got %b want 0", gate_open);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_quiet();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(24'h000100, 1'b1);
            n_vec++;
            if (got_valid !== 1'b1 || got_out !== 24'h0) begin
                n_err++;
                $display("FAIL quiet_out[%0d]: got v=%b %h want v=1 %h", i, got_valid, got_out,
                         24'h0);
            end
            n_vec++;
            if (got_gate !== 1'b0) begin
                n_err++;
                $display("FAIL quiet_gate[%0d]: got %b want 0", i, got_gate);
            end
        end
        idle();
    endtask

    task automatic test_attack();
        logic [23:0] exp_out;
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            send(24'h200000, 1'b1);
            exp_out = (n <= 16) ? 24'((n - 1) * 24'h020000) : 24'h200000;
            n_vec++;
            if (got_valid !== 1'b1 || got_out !== exp_out) begin
                n_err++;
                $display("FAIL attack_out[%0d]: got v=%b %h want v=1 %h", n, got_valid, got_out,
                         exp_out);
            end
            n_vec++;
            if (got_gate !== 1'b1) begin
                n_err++;
                $display("FAIL attack_gate[%0d]: got %b want 1", n, got_gate);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [23:0] vals [3];
        vals[0] = 24'h000001;
        vals[1] = 24'hFFFFFF;
        vals[2] = 24'h7FFFFF;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(vals[i], 1'b0);
            n_vec++;
            if (got_valid !== 1'b1 || got_out !== vals[i]) begin
                n_err++;
                $display("FAIL b2b_out[%0d]: got v=%b %h want v=1 %h", i, got_valid, got_out,
                         vals[i]);
            end
        end
        idle();
        n_vec++;
        if (got_valid !== 1'b0 || got_out !== 24'h7FFFFF) begin
            n_err++;
            $display("FAIL b2b_hold: got v=%b %h want v=0 %h", got_valid, got_out, 24'h7FFFFF);
        end
    endtask

    task automatic test_full_scale();
        do_reset();
        send(24'h800000, 1'b1);
        n_vec++;
        if (got_out !== 24'h0 || got_gate !== 1'b1) begin
            n_err++;
            $display("FAIL fs_first: got %h gate=%b want %h gate=1", got_out, got_gate, 24'h0);
        end
        n_vec++;
        if (dut.u_env.env_q !== 24'h7FFFFF) begin
            n_err++;
            $display("FAIL fs_env: got %h want %h", dut.u_env.env_q, 24'h7FFFFF);
        end
        send(24'h800000, 1'b1);
        n_vec++;
        if (got_out !== 24'hF80000) begin
            n_err++;
            $display("FAIL fs_neg_out: got %h want %h", got_out, 24'hF80000);
        end
        n_vec++;
        if (dut.u_env.env_q !== 24'h7F8000) begin
            n_err++;
            $display("FAIL fs_decay: got %h want %h", dut.u_env.env_q, 24'h7F8000);
        end
        idle();
    endtask

    task automatic test_release();
        int          env;
        int          n;
        int          gp;
        int          off;
        logic [23:0] exp_out;
        logic        exp_gate;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(24'h200000, 1'b1);
        end
        // Predict the first sample whose envelope falls below the close level.
        env = 24'h200000;
        n   = 0;
        for (int k = 1; k < 5000 && n == 0; k++) begin
            if (24'h004000 > env) env = 24'h004000;
            else env = env - (env >> 8);
            if (env < 24'h008000) n = k;
        end
        for (int k = 1; k <= n + 2670; k++) begin
            send(24'h004000, 1'b1);
            off      = k - n - 2402;
            gp       = (off <= 0) ? 256 : ((off >= 256) ? 0 : 256 - off);
            exp_out  = 24'(gp * 64);
            exp_gate = (k <= n + 2400);
            n_vec++;
            if (got_out !== exp_out) begin
                n_err++;
                $display("FAIL release_out[%0d]: got %h want %h", k, got_out, exp_out);
            end
            n_vec++;
            if (got_gate !== exp_gate) begin
                n_err++;
                $display("FAIL release_gate[%0d]: got %b want %b", k, got_gate, exp_gate);
            end
        end
        idle();
    endtask

    task automatic test_bypass();
        do_reset();
        send(24'h123456, 1'b0);
        n_vec++;
        if (got_valid !== 1'b1 || got_out !== 24'h123456) begin
            n_err++;
            $display("FAIL bypass_out: got v=%b %h want v=1 %h", got_valid, got_out, 24'h123456);
        end
        sample_valid = 1'b0;
        #2;
        enable = 1'b1;
        #3;
        enable = 1'b0;
        idle();
        n_vec++;
        if (got_valid !== 1'b0 || got_out !== 24'h123456) begin
            n_err++;
            $display("FAIL bypass_toggle: got v=%b %h want v=0 %h", got_valid, got_out,
                     24'h123456);
        end
        send(24'h800000, 1'b0);
        n_vec++;
        if (got_out !== 24'h800000) begin
            n_err++;
            $display("FAIL bypass_neg: got %h want %h", got_out, 24'h800000);
        end
        for (int i = 0; i < 14; i++) begin
            send(24'h200000, 1'b0);
        end
        // The gain ramp kept running while bypassed, so it is at unity now.
        send(24'h100000, 1'b1);
        n_vec++;
        if (got_out !== 24'h100000 || got_gate !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_fsm_ran: got %h gate=%b want %h gate=1", got_out, got_gate,
                     24'h100000);
        end
        idle();
    endtask

    task automatic test_reset_mid_attack();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(24'h200000, 1'b1);
        end
        n_vec++;
        if (got_out !== 24'h0E0000 || got_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got v=%b %h want v=1 %h", got_valid, got_out, 24'h0E0000);
        end
        sample_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sample_out !== 24'h0 || out_valid !== 1'b0 || gate_open !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: got %h v=%b g=%b want 0 v=0 g=0", sample_out,
                     out_valid, gate_open);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(24'h200000, 1'b1);
        n_vec++;
        if (got_out !== 24'h0 || got_gate !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_first: got %h g=%b want %h g=1", got_out, got_gate, 24'h0);
        end
        send(24'h200000, 1'b1);
        n_vec++;
        if (got_out !== 24'h020000) begin
            n_err++;
            $display("FAIL midrst_restart: got %h want %h", got_out, 24'h020000);
        end
        idle();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 24'h0;
        enable       = 1'b1;
        test_reset();
        test_quiet();
        test_attack();
        test_back_to_back();
        test_full_scale();
        test_release();
        test_bypass();
        test_reset_mid_attack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
